// File: rtl/dut.sv
// 17-tap symmetric RRC pulse-shaping FIR, 1s17 in/out; fold, multiply, sum pipeline.
// Latency 3 sys_clk edges from sample capture to y; DUT_SATURATE_EN selects clamping over wrap.
module dut #(
    parameter int NTAPS     = 17,
    parameter int COEF_FRAC = 17
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               clk,
    input  logic               sys_clk2_en,
    input  logic               sam_clk_en,
    input  logic signed [17:0] x_in,
    output logic signed [17:0] y
);
    localparam int NHALF = NTAPS / 2;

    function automatic logic signed [17:0] coef(input int k);
        case (k)
            0:       coef = 18'sd655;
            1:       coef = -18'sd2294;
            2:       coef = -18'sd4588;
            3:       coef = -18'sd4260;
            4:       coef = 18'sd1311;
            5:       coef = 18'sd9830;
            6:       coef = 18'sd20644;
            7:       coef = 18'sd29164;
            default: coef = 18'sd32768;
        endcase
    endfunction

    logic signed [17:0] x_q [NTAPS];
    logic signed [17:0] x_d [NTAPS];
    logic signed [18:0] p_q [NHALF+1];
    logic signed [18:0] p_d [NHALF+1];
    logic signed [36:0] m_q [NHALF+1];
    logic signed [36:0] m_d [NHALF+1];
    logic signed [40:0] sum_d;
    logic signed [40:0] shifted;
    logic signed [17:0] y_q;
    logic signed [17:0] y_d;

    // clk and sys_clk2_en exist only for pin compatibility; low sum bits drop out in the shift.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, sys_clk2_en, sum_d};

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            x_d[k] = x_q[k];
        end
        if (sam_clk_en) begin
            x_d[0] = x_in;
            for (int k = 1; k < NTAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
    end

    // Fold the symmetric taps before multiplying so only NHALF+1 products are needed.
    always_comb begin
        for (int k = 0; k < NHALF; k++) begin
            p_d[k] = 19'(x_q[k]) + 19'(x_q[NTAPS-1-k]);
        end
        p_d[NHALF] = 19'(x_q[NHALF]);
        for (int k = 0; k <= NHALF; k++) begin
            m_d[k] = 37'(p_q[k]) * 37'(coef(k));
        end
    end

    // The sum register is merged with y_q: the adder tree feeds the output flop directly.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k <= NHALF; k++) begin
            sum_d = sum_d + 41'(m_q[k]);
        end
        shifted = sum_d >>> COEF_FRAC;
`ifdef DUT_SATURATE_EN
        if (shifted > 41'sd131071) begin
            y_d = 18'sd131071;
        end else if (shifted < -41'sd131072) begin
            y_d = -18'sd131072;
        end else begin
            y_d = shifted[17:0];
        end
`else
        y_d = shifted[17:0];
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k <= NHALF; k++) begin
                p_q[k] <= '0;
                m_q[k] <= '0;
            end
            y_q <= '0;
        end else begin
            x_q <= x_d;
            p_q <= p_d;
            m_q <= m_d;
            y_q <= y_d;
        end
    end

    assign y = y_q;
endmodule

// File: tb/tb_dut.sv
// Directed-vector bench for the RRC FIR: reset, impulse, DC, overflow, back-to-back, mid-stream reset.
module tb_dut;
    logic               sys_clk = 1'b0;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sys_clk2_en = 1'b1;
    logic               sam_clk_en = 1'b0;
    logic signed [17:0] x_in = '0;
    logic signed [17:0] y;

    int n_tot = 0;
    int n_bad = 0;

    // h[k]*65536 >>> 17 = floor(h[k]/2), taps 0..16, then zero once the impulse leaves.
    int imp [18] = '{327, -1147, -2294, -2130, 655, 4915, 10322, 14582, 16384,
                     14582, 10322, 4915, 655, -2130, -2294, -1147, 327, 0};

    dut u_dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .clk        (clk),
        .sys_clk2_en(sys_clk2_en),
        .sam_clk_en (sam_clk_en),
        .x_in       (x_in),
        .y          (y)
    );

    always #5  sys_clk = ~sys_clk;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sam_clk_en = 1'b0;
        x_in = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_ovf;
        // Reset held with activity on the inputs
        reset = 1'b1;
        x_in = 18'sd12345;
        for (int i = 0; i < 4; i++) begin
            sam_clk_en = i[0];
            tick();
            chk("reset_hold", y, 0);
        end
        reset = 1'b0;
        x_in = '0;
        for (int i = 0; i < 6; i++) begin
            sam_clk_en = 1'b1;
            tick();
            chk("reset_release", y, 0);
        end

        // Impulse at nominal spacing, checking the 3-edge latency
        do_reset();
        for (int k = 0; k < 18; k++) begin
            sam_clk_en = 1'b1;
            x_in = (k == 0) ? 18'sd65536 : 18'sd0;
            tick();
            sam_clk_en = 1'b0;
            x_in = '0;
            tick();
            tick();
            chk("imp_pre", y, (k == 0) ? 0 : imp[k-1]);
            tick();
            chk("imp_val", y, imp[k]);
        end

        // DC settles to floor(133692 * 65536 / 2^17)
        do_reset();
        sam_clk_en = 1'b1;
        x_in = 18'sd65536;
        for (int i = 0; i < 20; i++) tick();
        sam_clk_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("dc", y, 66846);
        tick();
        chk("dc_hold", y, 66846);

        // Overflow: 131071*133692 >>> 17 = 133690, beyond 18-bit range
`ifdef DUT_SATURATE_EN
        exp_ovf = 131071;
`else
        exp_ovf = 133690 - 262144;
`endif
        do_reset();
        sam_clk_en = 1'b1;
        x_in = 18'sd131071;
        for (int i = 0; i < 20; i++) tick();
        sam_clk_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("overflow", y, exp_ovf);

        // Back-to-back enables: impulse values one per cycle, then held
        do_reset();
        for (int c = 0; c < 23; c++) begin
            sam_clk_en = (c < 17);
            x_in = (c == 0) ? 18'sd65536 : 18'sd0;
            tick();
            if (c >= 3) chk("b2b", y, imp[(c - 3 > 16) ? 16 : c - 3]);
            else        chk("b2b_fill", y, 0);
        end

        // Mid-stream reset during the impulse tail
        do_reset();
        for (int k = 0; k < 11; k++) begin
            sam_clk_en = 1'b1;
            x_in = (k == 0) ? 18'sd65536 : 18'sd0;
            tick();
            sam_clk_en = 1'b0;
            x_in = '0;
            tick();
            tick();
            tick();
        end
        chk("mid_before", y, imp[10]);
        reset = 1'b1;
        sam_clk_en = 1'b1;
        tick();
        chk("mid_reset", y, 0);
        reset = 1'b0;
        x_in = '0;
        for (int i = 0; i < 20; i++) begin
            sam_clk_en = 1'b1;
            tick();
            chk("mid_after", y, 0);
        end
        sam_clk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
